// File: rtl/arbiter_main.sv
// 16-way single-grant priority arbiter: one-hot grant plus binary index (16 = no request).
// Define ARBITER_ROUND_ROBIN_EN for a rotating-priority pointer; default is fixed priority, bit 0 first.
module arbiter_main (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ready,
    output logic [15:0] grant,
    output logic [4:0]  granted
);

    // Index of the lowest set bit, or 16 when the vector is empty.
    function automatic logic [4:0] lowest_index(input logic [15:0] v);
        logic [4:0] idx;
        idx = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

`ifdef ARBITER_ROUND_ROBIN_EN

    logic [3:0]  ptr;
    logic [15:0] rot;
    logic [4:0]  first;

    // Rotate so that ptr lands on bit 0, pick the lowest, then rotate the index back.
    always_comb begin
        rot = '0;
        for (int i = 0; i < 16; i++) begin
            rot[i] = ready[4'(i) + ptr];
        end
        first = lowest_index(rot);
        if (first[4]) begin
            granted = 5'd16;
        end else begin
            granted = {1'b0, first[3:0] + ptr};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr <= 4'd0;
        end else if (!granted[4]) begin
            ptr <= granted[3:0] + 4'd1;
        end
    end

`else

    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RESET;

    always_comb begin
        granted = lowest_index(ready);
    end

`endif

    always_comb begin
        grant = '0;
        if (!granted[4]) grant[granted[3:0]] = 1'b1;
    end

endmodule

// File: tb/tb_arbiter_main.sv
// Bench for arbiter_main: directed cases plus randomized ready against a search-order model.
module tb_arbiter_main;

    logic        CLK;
    logic        RESET;
    logic [15:0] ready;
    logic [15:0] grant;
    logic [4:0]  granted;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

`ifdef ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    arbiter_main dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ready   (ready),
        .grant   (grant),
        .granted (granted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Walk the requesters in priority order starting at p; first requester found wins.
    function automatic int model_pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return 16;
    endfunction

    function automatic logic [15:0] onehot(input int g);
        logic [15:0] v;
        v = '0;
        if (g < 16) v[g] = 1'b1;
        return v;
    endfunction

    // Called at a negedge: drive, check against exp_g, then cross the next posedge.
    task automatic cycle(input string tag, input logic [15:0] r, input int exp_g);
        ready = r;
        #1;
        check({tag, "_granted"}, 32'(granted), 32'(exp_g));
        check({tag, "_grant"}, 32'(grant), 32'(onehot(exp_g)));
        @(posedge CLK);
        if (!RESET) mptr = 0;
        else if (RR && exp_g != 16) mptr = (exp_g + 1) % 16;
        @(negedge CLK);
    endtask

    task automatic reset_pulse();
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        mptr = 0;
    endtask

    initial begin
        logic [15:0] r;
        RESET = 1'b0;
        ready = '0;
        @(negedge CLK);

        // Held in reset: every build behaves as fixed priority.
        for (int i = 0; i < 3; i++) cycle("rst_idle", 16'h0000, 16);
        cycle("fix_a4c0", 16'hA4C0, 6);
        cycle("fix_8000", 16'h8000, 15);
        cycle("fix_ffff", 16'hFFFF, 0);

        RESET = 1'b1;
        mptr = 0;
        for (int i = 0; i < 3; i++) cycle("idle", 16'h0000, 16);

`ifdef ARBITER_ROUND_ROBIN_EN
        reset_pulse();
        for (int i = 0; i < 17; i++) cycle("rr_ffff", 16'hFFFF, i % 16);

        reset_pulse();
        cycle("rr_0101_a", 16'h0101, 0);
        cycle("rr_0101_b", 16'h0101, 8);
        cycle("rr_0101_c", 16'h0101, 0);
        cycle("rr_0101_d", 16'h0101, 8);
        for (int i = 0; i < 3; i++) cycle("rr_gap", 16'h0000, 16);
        cycle("rr_0101_e", 16'h0101, 0);

        reset_pulse();
        cycle("rr_set_ptr", 16'h0100, 8);
        ready = 16'h0202;
        #1;
        check("rr_pre_rst", 32'(granted), 32'd9);
        RESET = 1'b0;
        #1;
        check("rr_async_granted", 32'(granted), 32'd1);
        check("rr_async_grant", 32'(grant), 32'h0002);
        @(negedge CLK);
        RESET = 1'b1;
        mptr = 0;
`else
        for (int i = 0; i < 4; i++) cycle("fix_hold", 16'hFFFF, 0);
        cycle("fix_0202", 16'h0202, 1);
        RESET = 1'b0;
        #1;
        check("fix_rst_no_effect", 32'(granted), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
`endif

        reset_pulse();
        for (int n = 0; n < 10000; n++) begin
            case ($urandom_range(0, 7))
                0:       r = 16'h0000;
                1:       r = onehot($urandom_range(0, 15));
                2:       r = 16'($urandom) & 16'($urandom);
                default: r = 16'($urandom);
            endcase
            cycle("rand", r, model_pick(r, mptr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
